// File: rtl/mem_writeback_pkg.sv
// mem_writeback_pkg: opcode constants, instruction field positions and stage state encoding
package mem_writeback_pkg;
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 11;
  localparam int RD_MSB  = 10;
  localparam int RD_LSB  = 8;
  localparam logic [4:0] OPC_NOP = 5'h00;
  localparam logic [4:0] OPC_ADD = 5'h01;
  localparam logic [4:0] OPC_LD  = 5'h02;
  localparam logic [4:0] OPC_ST  = 5'h03;
  localparam logic [4:0] OPC_SUB = 5'h04;
  localparam logic [4:0] OPC_MUL = 5'h05;
  localparam logic [4:0] OPC_CMP = 5'h06;
  localparam logic [4:0] OPC_MOV = 5'h07;
  localparam logic [4:0] OPC_OR  = 5'h08;
  localparam logic [4:0] OPC_AND = 5'h09;
  localparam logic [4:0] OPC_NOT = 5'h0A;
  localparam logic [4:0] OPC_LSL = 5'h0B;
  localparam logic [4:0] OPC_LSR = 5'h0C;
  typedef enum logic {IDLE, WAIT} state_t;
  function automatic logic is_alu_op(input logic [4:0] opc);
    return opc == OPC_ADD || opc == OPC_SUB || opc == OPC_MUL ||
           (opc >= OPC_MOV && opc <= OPC_LSR);
  endfunction
endpackage

// File: rtl/mem_writeback_if.sv
// mem_writeback_if: req/ack data-memory port between the write-back stage and memory
interface mem_writeback_if;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_ack, mem_rdata);
  modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_ack, mem_rdata);
endinterface

// File: rtl/mem_port_ctrl.sv
// mem_port_ctrl: WAIT state, timeout counter, req/ack handshake and sticky mem_err
module mem_port_ctrl
  import mem_writeback_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        mem_err,
  mem_writeback_if.master mem
);
  localparam int CW = $clog2(TIMEOUT) + 1;
  state_t        state;
  logic [CW-1:0] cnt;
  logic          expire;
  assign busy   = state == WAIT;
  assign done   = busy && mem.mem_ack;
  // an ack on the last allowed cycle still completes the access
  assign expire = busy && !mem.mem_ack && cnt == CW'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      mem_err       <= 1'b0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        state         <= WAIT;
        cnt           <= '0;
        mem.mem_req   <= 1'b1;
        mem.mem_we    <= we;
        mem.mem_addr  <= addr;
        mem.mem_wdata <= wdata;
      end
    end else if (done || expire) begin
      state       <= IDLE;
      mem.mem_req <= 1'b0;
      mem_err     <= mem_err | expire;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/mem_writeback.sv
// mem_writeback: decodes the retiring instruction, runs LD/ST on the memory port
// and drives single-cycle register-file write-back and retire pulses
module mem_writeback
  import mem_writeback_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instrin,
  input  logic [15:0] aluresult,
  input  logic [15:0] st_data,
  input  logic        is_branch_takenin,
  output logic        stall,
  mem_writeback_if.master mem,
  output logic        rf_we,
  output logic [2:0]  rf_waddr,
  output logic [15:0] rf_wdata,
  output logic [15:0] instrout,
  output logic        mem_err
);
  logic [4:0]  opc;
  logic [2:0]  rd;
  logic        busy, done, start, alu, ld_q, ld_done;
  logic [2:0]  rd_q;
  logic [15:0] instr_q;
  assign opc     = instrin[OPC_MSB:OPC_LSB];
  assign rd      = instrin[RD_MSB:RD_LSB];
  assign start   = !busy && !is_branch_takenin && (opc == OPC_LD || opc == OPC_ST);
  assign alu     = !busy && !is_branch_takenin && is_alu_op(opc);
  assign ld_done = done && ld_q;
  assign stall   = busy;
  mem_port_ctrl #(.TIMEOUT(TIMEOUT)) u_port (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .we      (opc == OPC_ST),
    .addr    (aluresult),
    .wdata   (st_data),
    .busy    (busy),
    .done    (done),
    .mem_err (mem_err),
    .mem     (mem)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      instrout <= '0;
      ld_q     <= 1'b0;
      rd_q     <= '0;
      instr_q  <= '0;
    end else begin
      rf_we    <= alu || ld_done;
      rf_waddr <= alu ? rd : ld_done ? rd_q : 3'd0;
      rf_wdata <= alu ? aluresult : ld_done ? mem.mem_rdata : 16'd0;
      instrout <= alu ? instrin : done ? instr_q : 16'd0;
      if (start) begin
        ld_q    <= opc == OPC_LD;
        rd_q    <= rd;
        instr_q <= instrin;
      end
    end
  end
endmodule

// File: tb/tb_mem_writeback.sv
// tb_mem_writeback: directed and randomized checks of mem_writeback against a retire-level model
module tb_mem_writeback;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] instrin = '0, aluresult = '0, st_data = '0;
  logic        is_branch_takenin = 1'b0;
  logic        stall, rf_we, mem_err;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata, instrout;
  int          ntot = 0, npass = 0, nfail = 0;
  bit          err_exp = 1'b0;

  always #5 clk = ~clk;

  mem_writeback_if mif ();

  mem_writeback #(.TIMEOUT(16)) dut (
    .clk               (clk),
    .reset             (reset),
    .instrin           (instrin),
    .aluresult         (aluresult),
    .st_data           (st_data),
    .is_branch_takenin (is_branch_takenin),
    .stall             (stall),
    .mem               (mif),
    .rf_we             (rf_we),
    .rf_waddr          (rf_waddr),
    .rf_wdata          (rf_wdata),
    .instrout          (instrout),
    .mem_err           (mem_err)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit retires_alu(input logic [4:0] o);
    return o inside {5'h01, 5'h04, 5'h05, [5'h07:5'h0C]};
  endfunction

  task automatic chk_retire(input bit we, input logic [15:0] ins, input logic [15:0] wd, input bit ret);
    chk("rf_we", 16'(rf_we), 16'(we));
    chk("rf_waddr", 16'(rf_waddr), we ? 16'(ins[10:8]) : 16'd0);
    chk("rf_wdata", rf_wdata, we ? wd : 16'd0);
    chk("instrout", instrout, ret ? ins : 16'd0);
  endtask

  // dly = WAIT cycle index on which mem_ack is raised; 16 or more never acks
  task automatic run(input logic [15:0] ins, input logic [15:0] alu, input logic [15:0] sd,
                     input bit fl, input int dly, input logic [15:0] rdat);
    logic [4:0] o;
    bit         is_mem, ret;
    o = ins[15:11];
    is_mem = (o == 5'h02 || o == 5'h03) && !fl;
    instrin = ins; aluresult = alu; st_data = sd; is_branch_takenin = fl;
    mif.mem_ack = 1'b0; mif.mem_rdata = 16'($urandom);
    @(posedge clk); #1;
    if (is_mem) begin
      chk_retire(1'b0, ins, 16'd0, 1'b0);
      chk("mem_addr", mif.mem_addr, alu);
      chk("mem_we", 16'(mif.mem_we), 16'(o == 5'h03));
      chk("mem_wdata", mif.mem_wdata, sd);
      for (int k = 0; k < 16; k++) begin
        chk("stall_wait", 16'(stall), 16'd1);
        chk("req_wait", 16'(mif.mem_req), 16'd1);
        instrin = 16'($urandom); aluresult = 16'($urandom); is_branch_takenin = 1'($urandom);
        mif.mem_ack = (k == dly);
        mif.mem_rdata = (k == dly) ? rdat : 16'($urandom);
        @(posedge clk); #1;
        if (k == dly) break;
      end
      mif.mem_ack = 1'b0;
      if (dly < 16) chk_retire(o == 5'h02, ins, rdat, 1'b1);
      else begin
        err_exp = 1'b1;
        chk_retire(1'b0, ins, 16'd0, 1'b0);
      end
      chk("req_drop", 16'(mif.mem_req), 16'd0);
    end else begin
      ret = !fl && retires_alu(o);
      chk_retire(ret, ins, alu, ret);
    end
    chk("stall", 16'(stall), 16'd0);
    chk("mem_err", 16'(mem_err), 16'(err_exp));
    instrin = '0; is_branch_takenin = 1'b0;
  endtask

  initial begin
    mif.mem_ack = 1'b0; mif.mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", 16'(stall), 16'd0);
    chk("rst_req", 16'(mif.mem_req), 16'd0);
    chk("rst_err", 16'(mem_err), 16'd0);
    chk_retire(1'b0, 16'd0, 16'd0, 1'b0);
    @(negedge clk) reset = 1'b1;
    run(16'h0A00, 16'h1234, 16'h0000, 1'b0, 0, 16'h0000);
    run(16'h1300, 16'h0040, 16'h0000, 1'b0, 3, 16'hBEEF);
    run(16'h1800, 16'h0010, 16'h5555, 1'b0, 1, 16'h0000);
    run(16'h1100, 16'h0020, 16'h0000, 1'b0, 20, 16'h0000);
    run(16'h0A00, 16'h1234, 16'h0000, 1'b0, 0, 16'h0000);
    run(16'h0A00, 16'h7777, 16'h0000, 1'b1, 0, 16'h0000);
    run(16'h0000, 16'h7777, 16'h0000, 1'b0, 0, 16'h0000);
    run(16'h3600, 16'h0001, 16'h0000, 1'b0, 0, 16'h0000);
    run(16'h1500, 16'h0100, 16'h0000, 1'b0, 15, 16'hCAFE);
    for (int i = 0; i < 80; i++) begin
      logic [15:0] ins;
      ins = {5'($urandom_range(0, 12)), 3'($urandom), 8'($urandom)};
      run(ins, 16'($urandom), 16'($urandom), ($urandom_range(0, 4) == 0),
          ($urandom_range(0, 9) == 0) ? 17 : int'($urandom_range(0, 15)), 16'($urandom));
    end
    instrin = 16'h1200; aluresult = 16'h0300; mif.mem_ack = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_stall", 16'(stall), 16'd1);
    reset = 1'b0;
    #2;
    chk("arst_req", 16'(mif.mem_req), 16'd0);
    chk("arst_stall", 16'(stall), 16'd0);
    chk("arst_rf_we", 16'(rf_we), 16'd0);
    chk("arst_err", 16'(mem_err), 16'd0);
    err_exp = 1'b0;
    instrin = '0;
    @(negedge clk) reset = 1'b1;
    run(16'h0A00, 16'h1234, 16'h0000, 1'b0, 0, 16'h0000);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
